// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a. Optional BREAK states exist only with UART_TX_BREAK_EN.
`timescale 1ns/1ps
package uart_pkg;

  // Clocks per bit for each unit of prescale unless the top overrides it.
  localparam int OVERSAMPLE_DEF = 8;

  // Frames never carry fewer than this many data bits.
  localparam int MIN_DATA_BITS = 5;

  // Parity mode as latched for a frame; the raw 2'b11 code folds into PAR_NONE.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  // Transmit FSM states. BREAK holds the line low; BRK_STOP is the one-bit
  // high marker that follows a break before the line returns to idle.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    ST_BREAK    = 3'd5,
    ST_BRK_STOP = 3'd6
`endif
  } state_e;

  // Map the raw register field onto a parity mode.
  function automatic parity_e decode_parity(input logic [1:0] raw);
    parity_e mode;
    case (raw)
      2'b01:   mode = PAR_EVEN;
      2'b10:   mode = PAR_ODD;
      default: mode = PAR_NONE;
    endcase
    return mode;
  endfunction

  // Clamp the requested data-bit count into [MIN_DATA_BITS, max_bits].
  function automatic logic [4:0] clamp_data_bits(input logic [3:0] raw, input int max_bits);
    logic [4:0] n;
    n = {1'b0, raw};
    if (int'(n) < MIN_DATA_BITS) begin
      n = 5'(MIN_DATA_BITS);
    end else if (int'(n) > max_bits) begin
      n = 5'(max_bits);
    end
    return n;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding words waiting for the framer, with a level output.
// Latency: a pushed word is visible on rd_dat the cycle after the push edge.
// Backpressure: wr_rdy drops when level reaches DEPTH; pops on an empty FIFO are ignored.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  input  logic [DW-1:0]            wr_dat,
  output logic                     wr_rdy,
  input  logic                     rd_pop,
  output logic [DW-1:0]            rd_dat,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push;
  logic          pop;

  assign wr_rdy = (level_q != LW'(DEPTH));
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_pop & (level_q != '0);
  assign rd_dat = mem_q[rd_ptr_q];
  assign level  = level_q;

  // Next pointers and level; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level state; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_dat;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: TX FIFO feeding a framer with per-frame data bits, parity and stop bits.
// Latency: a word pushed at edge N drives the start bit at edge N+2; bit period = max(prescale,1)*OVERSAMPLE.
// Backpressure: s_tready is low while the FIFO holds FIFO_DEPTH words. Optional macro: UART_TX_BREAK_EN.
`timescale 1ns/1ps
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 16,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [PRESCALE_W-1:0]       prescale,
  input  logic [3:0]                  cfg_data_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                        break_req
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  // Wide enough for (2^PRESCALE_W - 1) * OVERSAMPLE clocks without overflow.
  localparam int TW = PRESCALE_W + $clog2(OVERSAMPLE);

  state_e                state_q, state_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [4:0]            idx_q, idx_d;
  logic [4:0]            nbits_q, nbits_d;
  parity_e               par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_left_q, stop_left_d;
  logic                  par_acc_q, par_acc_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         per_m1_q, per_m1_d;
  logic                  fifo_vld_q, fifo_vld_d;

  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  rd_pop;
  logic                  fifo_nempty;
  logic [PRESCALE_W-1:0] pre_eff;
  logic [TW-1:0]         new_per_m1;
  logic                  bit_end;
  logic                  go_stop;
  logic                  start_frame;

  uart_tx_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (s_tvalid),
    .wr_dat (s_tdata),
    .wr_rdy (s_tready),
    .rd_pop (rd_pop),
    .rd_dat (rd_dat),
    .level  (fifo_level)
  );

  assign fifo_nempty = (fifo_level != LW'(0));
  assign rd_pop      = start_frame;
  assign txd         = txd_q;
  assign busy        = busy_q;

  // Bit period for a frame about to start; prescale of zero behaves as one.
  always_comb begin
    pre_eff    = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    new_per_m1 = TW'(pre_eff) * TW'(OVERSAMPLE) - TW'(1);
  end

  // Next-state logic: the timer counts down each bit; every state acts only at bit_end.
  always_comb begin
    state_d     = state_q;
    txd_d       = txd_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    nbits_d     = nbits_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    stop_left_d = stop_left_q;
    par_acc_d   = par_acc_q;
    per_m1_d    = per_m1_q;
    go_stop     = 1'b0;
    start_frame = 1'b0;
    bit_end     = (cnt_q == '0);
    cnt_d       = bit_end ? per_m1_q : cnt_q - TW'(1);
    // The IDLE pop decision looks at the FIFO state one cycle late, which puts
    // the start bit two edges after the push that filled an empty FIFO.
    fifo_vld_d  = fifo_nempty;

    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_d  = ST_BREAK;
          txd_d    = 1'b0;
          per_m1_d = new_per_m1;
        end else
`endif
        if (fifo_vld_q && fifo_nempty) begin
          start_frame = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          txd_d     = sh_q[0];
          sh_d      = sh_q >> 1;
          par_acc_d = sh_q[0];
          idx_d     = 5'd1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == nbits_q) begin
            if (par_q != PAR_NONE) begin
              state_d = ST_PARITY;
              txd_d   = (par_q == PAR_ODD) ? ~par_acc_q : par_acc_q;
            end else begin
              go_stop = 1'b1;
            end
          end else begin
            txd_d     = sh_q[0];
            sh_d      = sh_q >> 1;
            par_acc_d = par_acc_q ^ sh_q[0];
            idx_d     = idx_q + 5'd1;
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          go_stop = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (stop_left_q) begin
            stop_left_d = 1'b0;
          end else if (fifo_nempty) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!break_req) begin
          state_d = ST_BRK_STOP;
          txd_d   = 1'b1;
          cnt_d   = per_m1_q;
        end
      end

      ST_BRK_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (go_stop) begin
      state_d     = ST_STOP;
      txd_d       = 1'b1;
      stop_left_d = stop2_q;
    end

    // Frame start: pop the word and freeze the format and bit period for the whole frame.
    if (start_frame) begin
      state_d  = ST_START;
      txd_d    = 1'b0;
      sh_d     = rd_dat;
      nbits_d  = clamp_data_bits(cfg_data_bits, DATA_WIDTH);
      par_d    = decode_parity(cfg_parity);
      stop2_d  = cfg_stop2;
      per_m1_d = new_per_m1;
      cnt_d    = new_per_m1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM and datapath registers; reset abandons any frame and idles the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      sh_q        <= '0;
      idx_q       <= '0;
      nbits_q     <= 5'(MIN_DATA_BITS);
      par_q       <= PAR_NONE;
      stop2_q     <= 1'b0;
      stop_left_q <= 1'b0;
      par_acc_q   <= 1'b0;
      cnt_q       <= '0;
      per_m1_q    <= '0;
      fifo_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      sh_q        <= sh_d;
      idx_q       <= idx_d;
      nbits_q     <= nbits_d;
      par_q       <= par_d;
      stop2_q     <= stop2_d;
      stop_left_q <= stop_left_d;
      par_acc_q   <= par_acc_d;
      cnt_q       <= cnt_d;
      per_m1_q    <= per_m1_d;
      fifo_vld_q  <= fifo_vld_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frame table, multi-cycle corner sequences, random streams.
// Latency: n/a. Backpressure: the bench holds s_tvalid until s_tready is seen.
// Optional BREAK sequence runs only when UART_TX_BREAK_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] prescale;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        txd;
  logic        busy;
  logic [2:0]  fifo_level;
`ifdef UART_TX_BREAK_EN
  logic        break_req;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .PRESCALE_W (16),
    .OVERSAMPLE (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .prescale      (prescale),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .txd           (txd),
    .busy          (busy),
    .fifo_level    (fifo_level)
`ifdef UART_TX_BREAK_EN
    ,
    .break_req     (break_req)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference frame: start bit, clamped data bits LSB first, parity from the
  // count of transmitted ones, then one or two stop bits.
  function automatic void model(input logic [7:0] w, input logic [3:0] nb, input logic [1:0] par,
                                input logic s2, output logic [15:0] bits, output int len);
    int n;
    int ones;
    n    = (nb < 4'd5) ? 5 : ((nb > 4'd8) ? 8 : int'(nb));
    bits = '0;
    len  = 0;
    ones = 0;
    bits[len] = 1'b0; len++;
    for (int i = 0; i < n; i++) begin
      bits[len] = w[i];
      ones += int'(w[i]);
      len++;
    end
    if (par == 2'b01) begin
      bits[len] = (ones % 2 == 1); len++;
    end else if (par == 2'b10) begin
      bits[len] = (ones % 2 == 0); len++;
    end
    bits[len] = 1'b1; len++;
    if (s2) begin
      bits[len] = 1'b1; len++;
    end
  endfunction

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic s2, input logic [15:0] pre);
    @(negedge clk);
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop2     = s2;
    prescale      = pre;
  endtask

  // Push one word; returns at the negedge following the push edge.
  task automatic push(input logic [7:0] w);
    int g;
    @(negedge clk);
    s_tdata  = w;
    s_tvalid = 1'b1;
    g = 0;
    while (s_tready !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) chk("push_timeout", 32'(s_tready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  // Wait for a start bit (gap = negedges waited, -1 to skip), sample every bit mid-period,
  // optionally check busy stays high for exactly len*per clocks.
  task automatic check_frame(input logic [15:0] bits, input int len, input int per,
                             input int gap, input bit chk_idle, input string tag);
    int w;
    int c;
    w = 0;
    while (txd !== 1'b0 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start"}, 32'(txd), 32'd0);
    if (gap >= 0) chk({tag, "_gap"}, 32'(w), 32'(gap));
    c = 0;
    for (int i = 0; i < len; i++) begin
      while (c < i * per + per / 2) begin
        @(negedge clk);
        c++;
      end
      chk($sformatf("%s_bit%0d", tag, i), 32'(txd), 32'(bits[i]));
      if (i == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    if (chk_idle) begin
      while (c < len * per - 1) begin
        @(negedge clk);
        c++;
      end
      chk({tag, "_busy_last"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_txd_end"}, 32'(txd), 32'd1);
    end
  endtask

  // Send n words through the FIFO while decoding them on txd, in order.
  task automatic stream(input int n, input bit rnd_gap, input int per, input string tag);
    logic [7:0]  ws [8];
    logic [15:0] bits;
    int          len;
    int          full;
    full = 0;
    for (int k = 0; k < n; k++) ws[k] = 8'($urandom_range(0, 255));
    @(negedge clk);
    fork
      begin : pusher
        int g;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
          s_tdata  = ws[k];
          s_tvalid = 1'b1;
          g = 0;
          while (s_tready !== 1'b1 && g < 5000) begin
            chk({tag, "_full_level"}, 32'(fifo_level), 32'd4);
            full++;
            @(negedge clk);
            g++;
          end
          @(posedge clk);
          @(negedge clk);
          if (rnd_gap) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(0, 20)) @(negedge clk);
          end
        end
        s_tvalid = 1'b0;
      end
      begin : monitor
        for (int k = 0; k < n; k++) begin
          model(ws[k], cfg_data_bits, cfg_parity, cfg_stop2, bits, len);
          check_frame(bits, len, per, rnd_gap ? -1 : ((k == 0) ? 4 : per - per / 2),
                      (k == n - 1), $sformatf("%s_f%0d", tag, k));
        end
      end
    join
    if (!rnd_gap) chk({tag, "_saw_full"}, 32'(full > 0), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  dat;
    logic [3:0]  nb;
    logic [1:0]  par;
    logic        s2;
    logic [15:0] pre;
    int          len;
    logic [15:0] bits;
    int          per;
  } vec_t;

  vec_t vec [5];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] bits;
    int          len;
    int          w;
    int          errs;

    // Directed frames: expected txd sequence (bit i = i-th bit on the line) and bit period.
    vec[0] = '{8'hA5, 4'd8,  2'b01, 1'b0, 16'd2, 11, 16'b0000010101001010, 16};
    vec[1] = '{8'h80, 4'd7,  2'b10, 1'b1, 16'd3, 11, 16'b0000011100000000, 24};
    vec[2] = '{8'h1F, 4'd5,  2'b00, 1'b0, 16'd1, 7,  16'b0000000001111110, 8};
    vec[3] = '{8'h0A, 4'd3,  2'b01, 1'b0, 16'd1, 8,  16'b0000000010010100, 8};
    vec[4] = '{8'h3C, 4'd15, 2'b11, 1'b1, 16'd2, 11, 16'b0000011001111000, 16};

    rst           = 1'b1;
    s_tdata       = '0;
    s_tvalid      = 1'b0;
    prescale      = 16'd1;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
`ifdef UART_TX_BREAK_EN
    break_req     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_tready", 32'(s_tready), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table: push at edge N must show the start bit after edge N+2 (gap 2).
    for (int r = 0; r < 5; r++) begin
      set_cfg(vec[r].nb, vec[r].par, vec[r].s2, vec[r].pre);
      push(vec[r].dat);
      check_frame(vec[r].bits, vec[r].len, vec[r].per, 2, 1'b1, $sformatf("vec%0d", r));
    end

    // prescale=0 gives 8-clock bits; changing it mid-frame only affects the next frame.
    set_cfg(4'd8, 2'b00, 1'b0, 16'd0);
    push(8'hC3);
    fork
      begin
        model(8'hC3, 4'd8, 2'b00, 1'b0, bits, len);
        check_frame(bits, len, 8, 2, 1'b0, "pre0_a");
      end
      begin
        repeat (20) @(negedge clk);
        prescale = 16'd4;
        push(8'h5A);
      end
    join
    model(8'h5A, 4'd8, 2'b00, 1'b0, bits, len);
    check_frame(bits, len, 32, 4, 1'b1, "pre4_b");

    // Six words with s_tvalid held: FIFO fills, frames leave back to back.
    set_cfg(4'd8, 2'b01, 1'b0, 16'd1);
    stream(6, 1'b0, 8, "b2b");

    // Asynchronous reset during data bit 3 with a second word queued.
    set_cfg(4'd8, 2'b00, 1'b0, 16'd1);
    push(8'h55);
    push(8'h33);
    w = 0;
    while (txd !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("rst_frame_start", 32'(txd), 32'd0);
    repeat (36) @(negedge clk);
    chk("rst_pre_level", 32'(fifo_level), 32'd1);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("rst_no_residual", 32'(errs), 32'd0);

    // Random formats and words with random gaps between pushes.
    for (int b = 0; b < 4; b++) begin
      logic [15:0] pre;
      pre = 16'($urandom_range(0, 2));
      set_cfg(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pre);
      stream(5, 1'b1, (pre == 16'd0) ? 8 : int'(pre) * 8, $sformatf("rnd%0d", b));
    end

`ifdef UART_TX_BREAK_EN
    // Break with one word queued: line low, one high bit period, back to IDLE
    // for one cycle, then the queued frame.
    set_cfg(4'd8, 2'b00, 1'b0, 16'd1);
    @(negedge clk);
    break_req = 1'b1;
    push(8'h96);
    repeat (50) @(negedge clk);
    chk("brk_txd_low", 32'(txd), 32'd0);
    chk("brk_busy", 32'(busy), 32'd1);
    chk("brk_level", 32'(fifo_level), 32'd1);
    repeat (48) @(negedge clk);
    break_req = 1'b0;
    w = 0;
    @(negedge clk);
    while (txd === 1'b1 && w < 1000) begin
      w++;
      @(negedge clk);
    end
    chk("brk_release_high", 32'(w), 32'd9);
    model(8'h96, 4'd8, 2'b00, 1'b0, bits, len);
    check_frame(bits, len, 8, 0, 1'b1, "brk_frame");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
